cnn_data_combine_pp: RTL and testbench
======================================

# cnn_data_combine_pp

Parametrised, double-buffered successor to the CNN input combiner. It collects address-indexed bus words into one of two packed banks. Each bank holds one feature-map window, the kernel weights and the biases. A full bank is presented to the CNN core through a valid/ready handshake while the other bank loads. It adds a fmap-only reload mode that reuses the weights and bias from the previous load, plus range and length error flags. It sits between the AXI-side word source and `cnn_core`.

## Interface
Parameters:
- `CI`, `CO`, `KX`, `KY`, `I_F_BW`, `W_BW`, `B_BW`: taken from `defines_cnn_core.vh`; overridable per instance.
- `BUS_W`: 32. Write word width.
- Derived:
  - `F_BITS = CI*KX*KY*I_F_BW`
  - `W_BITS = CO*CI*KX*KY*W_BW`
  - `B_BITS = CO*B_BW`
  - `TOT_BITS = F_BITS + W_BITS + B_BITS`
  - `NWORDS = ceil(TOT_BITS/BUS_W)`
  - `FWORDS = ceil(F_BITS/BUS_W)`
  - `AW = clog2(NWORDS)`

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: write beat offered.
- `wr_ready` out 1: beat accepted when high with `wr_valid`.
- `wr_addr` in `AW`: word index within the packed image.
- `wr_data` in `BUS_W`: word payload.
- `wr_last` in 1: final beat of the load.
- `wr_mode` in 1: 0 = full load, 1 = fmap-only; sampled on the first beat of a load.
- `out_valid` out 1: read bank holds a complete image.
- `out_ready` in 1: core consumes the image.
- `out_fmap` out `F_BITS`: image bits [F_BITS-1:0].
- `out_weight` out `W_BITS`, signed: next `W_BITS` bits.
- `out_bias` out `B_BITS`, signed: top `B_BITS` bits.
- `err_addr` out 1: sticky; an out-of-range address was received.
- `err_len` out 1: sticky; `wr_last` arrived with the wrong beat count.
- `err_clr` in 1: clears both error flags.

## Operation
Storage:
- Two banks, `bank[0..1]`, each `NWORDS*BUS_W` bits. Word k occupies bits [k*BUS_W +: BUS_W]. Bits above `TOT_BITS` are ignored.
- State: write pointer `wp`, read pointer `rp`, flags `full[1:0]`, beat counter `cnt`, latched mode `mode_q`, flag `busy` (a load is in progress).

Write side (IDLE -> FILL -> IDLE):
- `wr_ready = ~full[wp]`.
- **IDLE, first accepted beat:** latch `mode_q = wr_mode` and set `busy`. If `wr_mode = 1`, in the same cycle copy the weight and bias fields (bits [TOT_BITS-1:F_BITS]) of `bank[~wp]` into `bank[wp]`.
- **Accepted beat, legal address:** write the word. In mode 1, bits at or above `F_BITS` within the word are masked, so the copied weights survive a partial last fmap word.
- **Legal address limit:** `wr_addr < NWORDS` in mode 0, `wr_addr < FWORDS` in mode 1.
- **Illegal address:** beat is accepted and dropped; set `err_addr`.
- **`cnt`:** counts accepted beats, legal and illegal.
- **Accepted beat with `wr_last`:** set `full[wp]`, toggle `wp`, clear `busy` and `cnt`. If the beat count including this beat differs from the expected count (`NWORDS` in mode 0, `FWORDS` in mode 1), set `err_len`. Unwritten words keep their stale contents.

Read side:
- `out_valid = full[rp]`.
- Outputs are driven from `bank[rp]` while `out_valid` is high, and are 0 otherwise.
- `out_valid & out_ready` clears `full[rp]` and toggles `rp`. Bank contents are not cleared.

Boundary conditions:
- **Load completion and consume in the same cycle:** both take effect. They always target different banks.
- **Both banks full:** `wr_ready = 0`. An unconsumed image is never overwritten.
- **`err_clr` and a new error in the same cycle:** the flag stays set; set wins.
- **Mode 1 as the first load after reset:** weights and bias are copied from the zeroed bank, giving weights/bias = 0.
- **Reset mid-load:** the partial load is discarded.

## Timing
- **Reset values:**
  - Banks: 0. `full`, `wp`, `rp`, `cnt`, `busy`: 0. `err_*`: 0.
  - Outputs: `wr_ready = 1`, `out_valid = 0`, `out_fmap`/`out_weight`/`out_bias` = 0.
- **Write latency:** a beat accepted at edge N is stored at edge N.
- **Load latency:** for a beat with `wr_last` accepted at edge N, `out_valid` rises after edge N, when the read side is on that bank.
- **Back-to-back loads:** supported at 1 beat per cycle with no bubbles while a bank is free.
- **`wr_ready` after a free:** rises in the cycle after the consume that freed a bank.
- **Output stability:** outputs are stable from `out_valid` rising until the consume edge.

## Structure
- **Shared package (`defines_cnn_core.vh` plus `cnn_combine_pkg`):**
  - Derived widths `F_BITS`, `W_BITS`, `B_BITS`, `TOT_BITS`, `NWORDS`, `FWORDS`, `AW`.
  - Field offset constants.
  - Mode encoding: `MODE_FULL = 0`, `MODE_FMAP = 1`.
- **Sub-module `cnn_combine_bank`:** instantiated twice. One bank register with:
  - a word write port with a bit mask;
  - a weight/bias field load port;
  - a full-image read port.
- The top level holds the pointers, `full` flags, counter, error logic and output gating.

## Test plan
All scenarios use CI=1, CO=1, KX=KY=3, I_F_BW=8, W_BW=8, B_BW=16. This gives TOT_BITS=160, NWORDS=5, FWORDS=3.

1. **Full load:** addresses 0..4 with data 0x11111111..0x55555555, `wr_last` on address 4 -> `out_valid` the next cycle; `out_bias = 0x5555`; `out_fmap[71:64] = 0x33`; `err_*` = 0.
2. **Ping-pong with a stalled core:** two full loads with `out_ready = 0` -> `wr_ready` drops after the second `wr_last` and a third load stalls. `out_ready` for 1 cycle -> first image consumed, second image presented, `wr_ready` rises the next cycle.
3. **Fmap-only reload:** after scenario 1 is consumed, a mode-1 load of addresses 0..2 with data 0xAAAAAAAA -> `out_fmap` is all 0xAA; `out_weight`/`out_bias` equal the scenario-1 values, including weight bits [95:72] = 0x333333.
4. **Illegal address:** mode 0, `wr_addr = 6` -> beat dropped, `err_addr = 1` until `err_clr`. In mode 1, `wr_addr = 3` -> `err_addr = 1`.
5. **Short load:** `wr_last` on the 3rd beat in mode 0 -> `err_len = 1`; image presented with stale words 3..4.
6. **Reset mid-load:** `reset` after 2 beats -> `out_valid = 0`, `wr_ready = 1`, all outputs 0. A following full load behaves as in scenario 1.

Source files
------------

// File: rtl/cnn_combine_pkg.sv
// rtl/cnn_combine_pkg.sv - default CNN geometry, derived image widths and load-mode encoding
package cnn_combine_pkg;

    localparam int DEF_CI     = 1;
    localparam int DEF_CO     = 1;
    localparam int DEF_KX     = 3;
    localparam int DEF_KY     = 3;
    localparam int DEF_I_F_BW = 8;
    localparam int DEF_W_BW   = 8;
    localparam int DEF_B_BW   = 16;
    localparam int DEF_BUS_W  = 32;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int addr_bits(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    localparam int DEF_F_BITS   = DEF_CI * DEF_KX * DEF_KY * DEF_I_F_BW;
    localparam int DEF_W_BITS   = DEF_CO * DEF_CI * DEF_KX * DEF_KY * DEF_W_BW;
    localparam int DEF_B_BITS   = DEF_CO * DEF_B_BW;
    localparam int DEF_TOT_BITS = DEF_F_BITS + DEF_W_BITS + DEF_B_BITS;
    localparam int DEF_NWORDS   = ceil_div(DEF_TOT_BITS, DEF_BUS_W);
    localparam int DEF_FWORDS   = ceil_div(DEF_F_BITS, DEF_BUS_W);
    localparam int DEF_AW       = addr_bits(DEF_NWORDS);

    // Field offsets inside the packed image: fmap at 0, weights next, bias on top.
    localparam int DEF_W_OFF = DEF_F_BITS;
    localparam int DEF_B_OFF = DEF_F_BITS + DEF_W_BITS;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_FMAP = 1'b1;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/cnn_data_combine_pp_if.sv
// rtl/cnn_data_combine_pp_if.sv - word-source, core-side and error signals of the combiner
interface cnn_data_combine_pp_if
    import cnn_combine_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int BUS_W  = DEF_BUS_W,
    parameter int F_BITS = DEF_F_BITS,
    parameter int W_BITS = DEF_W_BITS,
    parameter int B_BITS = DEF_B_BITS
) ();

    logic                     wr_valid;
    logic                     wr_ready;
    logic [AW-1:0]            wr_addr;
    logic [BUS_W-1:0]         wr_data;
    logic                     wr_last;
    logic                     wr_mode;

    logic                     out_valid;
    logic                     out_ready;
    logic [F_BITS-1:0]        out_fmap;
    logic signed [W_BITS-1:0] out_weight;
    logic signed [B_BITS-1:0] out_bias;

    logic                     err_addr;
    logic                     err_len;
    logic                     err_clr;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_last, wr_mode, out_ready, err_clr,
        input  wr_ready, out_valid, out_fmap, out_weight, out_bias, err_addr, err_len
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last, wr_mode, out_ready, err_clr,
        output wr_ready, out_valid, out_fmap, out_weight, out_bias, err_addr, err_len
    );

endinterface

// File: rtl/cnn_combine_bank.sv
// rtl/cnn_combine_bank.sv - one packed image bank with masked word write and weight/bias field load
module cnn_combine_bank #(
    parameter int BUS_W    = 32,
    parameter int NWORDS   = 5,
    parameter int AW       = 3,
    parameter int F_BITS   = 72,
    parameter int TOT_BITS = 160
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [BUS_W-1:0]          data_i,
    input  logic [BUS_W-1:0]          mask_i,
    input  logic                      ld_i,
    input  logic [TOT_BITS-F_BITS-1:0] ld_data_i,
    output logic [NWORDS*BUS_W-1:0]   rd_data_o
);

    localparam int IMG_W = NWORDS * BUS_W;

    logic [IMG_W-1:0] mem_q;
    logic [IMG_W-1:0] mem_d;
    logic [BUS_W-1:0] old_word;

    // The field copy is applied first so masked-off bits of the word keep the copied value.
    always_comb begin
        mem_d    = mem_q;
        old_word = '0;
        if (ld_i) begin
            mem_d[TOT_BITS-1:F_BITS] = ld_data_i;
        end
        if (we_i) begin
            old_word = mem_d[int'(addr_i)*BUS_W +: BUS_W];
            mem_d[int'(addr_i)*BUS_W +: BUS_W] = (old_word & ~mask_i) | (data_i & mask_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_o = mem_q;

endmodule

// File: rtl/cnn_data_combine_pp.sv
// rtl/cnn_data_combine_pp.sv - double-buffered combiner of bus words into fmap/weight/bias images
module cnn_data_combine_pp
    import cnn_combine_pkg::*;
#(
    parameter int CI     = DEF_CI,
    parameter int CO     = DEF_CO,
    parameter int KX     = DEF_KX,
    parameter int KY     = DEF_KY,
    parameter int I_F_BW = DEF_I_F_BW,
    parameter int W_BW   = DEF_W_BW,
    parameter int B_BW   = DEF_B_BW,
    parameter int BUS_W  = DEF_BUS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cnn_data_combine_pp_if.slave bus
);

    localparam int F_BITS   = CI * KX * KY * I_F_BW;
    localparam int W_BITS   = CO * CI * KX * KY * W_BW;
    localparam int B_BITS   = CO * B_BW;
    localparam int TOT_BITS = F_BITS + W_BITS + B_BITS;
    localparam int NWORDS   = ceil_div(TOT_BITS, BUS_W);
    localparam int FWORDS   = ceil_div(F_BITS, BUS_W);
    localparam int AW       = addr_bits(NWORDS);
    localparam int IMG_W    = NWORDS * BUS_W;
    localparam int W_OFF    = F_BITS;
    localparam int B_OFF    = F_BITS + W_BITS;
    localparam int CW       = $clog2(NWORDS + 2) + 1;

    wr_state_e         state_q;
    logic              wp_q;
    logic              rp_q;
    logic              mode_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              err_addr_q;
    logic              err_addr_d;
    logic              err_len_q;
    logic              err_len_d;

    logic              accept;
    logic              first_beat;
    logic              cur_mode;
    logic              legal;
    logic              last_beat;
    logic              len_bad;
    logic              consume;
    logic [BUS_W-1:0]  wmask;
    logic [1:0]        bank_we;
    logic [1:0]        bank_ld;
    logic [IMG_W-1:0]  rd_data0;
    logic [IMG_W-1:0]  rd_data1;
    logic [IMG_W-1:0]  img;

    assign bus.wr_ready = ~full_q[wp_q];
    assign accept       = bus.wr_valid & bus.wr_ready;
    assign first_beat   = accept & (state_q == WR_IDLE);
    assign cur_mode     = (state_q == WR_IDLE) ? bus.wr_mode : mode_q;
    assign legal        = (cur_mode == MODE_FMAP) ? (int'(bus.wr_addr) < FWORDS)
                                                  : (int'(bus.wr_addr) < NWORDS);
    assign last_beat    = accept & bus.wr_last;

    // Counter saturates so a runaway load still reports a length error.
    assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign len_bad = last_beat & (int'(cnt_d) != ((cur_mode == MODE_FMAP) ? FWORDS : NWORDS));

    // In fmap-only mode the bits that belong to weights/bias are protected.
    always_comb begin
        wmask = '1;
        if (cur_mode == MODE_FMAP) begin
            for (int j = 0; j < BUS_W; j++) begin
                if (int'(bus.wr_addr) * BUS_W + j >= F_BITS) begin
                    wmask[j] = 1'b0;
                end
            end
        end
    end

    assign bank_we[0] = accept & legal & ~wp_q;
    assign bank_we[1] = accept & legal & wp_q;
    assign bank_ld[0] = first_beat & (bus.wr_mode == MODE_FMAP) & ~wp_q;
    assign bank_ld[1] = first_beat & (bus.wr_mode == MODE_FMAP) & wp_q;

    cnn_combine_bank #(
        .BUS_W(BUS_W), .NWORDS(NWORDS), .AW(AW), .F_BITS(F_BITS), .TOT_BITS(TOT_BITS)
    ) u_bank0 (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bank_we[0]),
        .addr_i    (bus.wr_addr),
        .data_i    (bus.wr_data),
        .mask_i    (wmask),
        .ld_i      (bank_ld[0]),
        .ld_data_i (rd_data1[TOT_BITS-1:F_BITS]),
        .rd_data_o (rd_data0)
    );

    cnn_combine_bank #(
        .BUS_W(BUS_W), .NWORDS(NWORDS), .AW(AW), .F_BITS(F_BITS), .TOT_BITS(TOT_BITS)
    ) u_bank1 (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bank_we[1]),
        .addr_i    (bus.wr_addr),
        .data_i    (bus.wr_data),
        .mask_i    (wmask),
        .ld_i      (bank_ld[1]),
        .ld_data_i (rd_data0[TOT_BITS-1:F_BITS]),
        .rd_data_o (rd_data1)
    );

    assign consume = bus.out_valid & bus.out_ready;

    // Completion and consume always hit different banks, so both updates apply.
    always_comb begin
        full_d = full_q;
        if (last_beat) begin
            full_d[wp_q] = 1'b1;
        end
        if (consume) begin
            full_d[rp_q] = 1'b0;
        end
    end

    assign err_addr_d = (err_addr_q & ~bus.err_clr) | (accept & ~legal);
    assign err_len_d  = (err_len_q & ~bus.err_clr) | len_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WR_IDLE;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            mode_q     <= MODE_FULL;
            full_q     <= '0;
            cnt_q      <= '0;
            err_addr_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            if (first_beat) begin
                mode_q <= bus.wr_mode;
            end
            if (accept) begin
                if (bus.wr_last) begin
                    state_q <= WR_IDLE;
                    cnt_q   <= '0;
                    wp_q    <= ~wp_q;
                end else begin
                    state_q <= WR_FILL;
                    cnt_q   <= cnt_d;
                end
            end
            if (consume) begin
                rp_q <= ~rp_q;
            end
            full_q     <= full_d;
            err_addr_q <= err_addr_d;
            err_len_q  <= err_len_d;
        end
    end

    assign img           = rp_q ? rd_data1 : rd_data0;
    assign bus.out_valid = full_q[rp_q];
    assign bus.out_fmap   = bus.out_valid ? img[F_BITS-1:0]     : '0;
    assign bus.out_weight = bus.out_valid ? img[W_OFF +: W_BITS] : '0;
    assign bus.out_bias   = bus.out_valid ? img[B_OFF +: B_BITS] : '0;
    assign bus.err_addr   = err_addr_q;
    assign bus.err_len    = err_len_q;

endmodule

// File: tb/tb_cnn_data_combine_pp.sv
// tb/tb_cnn_data_combine_pp.sv - directed bench for the double-buffered CNN data combiner
module tb_cnn_data_combine_pp;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cnn_data_combine_pp_if bus ();

    cnn_data_combine_pp #(
        .CI(1), .CO(1), .KX(3), .KY(3), .I_F_BW(8), .W_BW(8), .B_BW(16), .BUS_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [71:0] S1_FMAP   = 72'h33_22222222_11111111;
    localparam logic [71:0] S1_WEIGHT = 72'h5555_44444444_333333;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] a, input logic [31:0] d, input logic last, input logic mode);
        int n;
        n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_last  = last;
        bus.wr_mode  = mode;
        while (bus.wr_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("wr_ready_timeout", 160'd0, 160'd1);
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic load_s1();
        for (int k = 0; k < 5; k++) begin
            beat(3'(k), 32'h11111111 * (k + 1), k == 4, 1'b0);
        end
    endtask

    task automatic check_s1(input string tag);
        chk({tag, "_valid"},  bus.out_valid, 1'b1);
        chk({tag, "_bias"},   $unsigned(bus.out_bias), 16'h5555);
        chk({tag, "_fmap_hi"}, bus.out_fmap[71:64], 8'h33);
        chk({tag, "_fmap"},   bus.out_fmap, S1_FMAP);
        chk({tag, "_weight"}, $unsigned(bus.out_weight), S1_WEIGHT);
        chk({tag, "_errs"},   {bus.err_addr, bus.err_len}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_last   = 1'b0;
        bus.wr_mode   = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_wr_ready",  bus.wr_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_fmap",      bus.out_fmap, 72'd0);
        chk("rst_weight",    $unsigned(bus.out_weight), 72'd0);
        chk("rst_bias",      $unsigned(bus.out_bias), 16'd0);
        chk("rst_errs",      {bus.err_addr, bus.err_len}, 2'b00);

        // full load
        load_s1();
        check_s1("s1");
        consume();
        chk("s1_consumed", bus.out_valid, 1'b0);

        // fmap-only reload reuses the weights/bias just consumed
        for (int k = 0; k < 3; k++) beat(3'(k), 32'hAAAAAAAA, k == 2, 1'b1);
        chk("s3_fmap",   bus.out_fmap, 72'hAAAAAAAAAAAAAAAAAA);
        chk("s3_weight", $unsigned(bus.out_weight), S1_WEIGHT);
        chk("s3_w_low",  bus.out_weight[23:0], 24'h333333);
        chk("s3_bias",   $unsigned(bus.out_bias), 16'h5555);
        consume();

        // ping-pong with a stalled core
        for (int k = 0; k < 5; k++) beat(3'(k), 32'h100 + k, k == 4, 1'b0);
        for (int k = 0; k < 5; k++) beat(3'(k), 32'h200 + k, k == 4, 1'b0);
        chk("s2_both_full_ready", bus.wr_ready, 1'b0);
        chk("s2_first_valid",     bus.out_valid, 1'b1);
        chk("s2_first_img",       bus.out_fmap[31:0], 32'h100);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 32'h999;
        repeat (3) tick();
        chk("s2_stalled_ready", bus.wr_ready, 1'b0);
        chk("s2_stalled_img",   bus.out_fmap[31:0], 32'h100);
        bus.wr_valid = 1'b0;
        consume();
        chk("s2_second_valid", bus.out_valid, 1'b1);
        chk("s2_second_img",   bus.out_fmap[31:0], 32'h200);
        chk("s2_ready_back",   bus.wr_ready, 1'b1);
        consume();

        // illegal address in full mode, word 2 left stale
        beat(3'd0, 32'hC0, 1'b0, 1'b0);
        beat(3'd1, 32'hC1, 1'b0, 1'b0);
        beat(3'd6, 32'hC6, 1'b0, 1'b0);
        chk("s4_err_addr_set", bus.err_addr, 1'b1);
        beat(3'd3, 32'hC3, 1'b0, 1'b0);
        beat(3'd4, 32'hC4, 1'b1, 1'b0);
        chk("s4_err_addr_sticky", bus.err_addr, 1'b1);
        chk("s4_err_len",         bus.err_len, 1'b0);
        chk("s4_fmap",            bus.out_fmap, 72'h02_000000C1_000000C0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("s4_err_clr", bus.err_addr, 1'b0);
        consume();

        // illegal address in fmap-only mode; copy comes from the previous bank
        beat(3'd0, 32'hD0, 1'b0, 1'b1);
        beat(3'd3, 32'hD3, 1'b0, 1'b1);
        chk("s4m1_err_addr", bus.err_addr, 1'b1);
        beat(3'd2, 32'hD2, 1'b1, 1'b1);
        chk("s4m1_fmap",    bus.out_fmap, 72'hD2_00000201_000000D0);
        chk("s4m1_weight",  $unsigned(bus.out_weight), 72'h00C4_000000C3_000001);
        chk("s4m1_bias",    $unsigned(bus.out_bias), 16'h0000);
        chk("s4m1_err_len", bus.err_len, 1'b0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        consume();

        // short load; clear coincides with the new length error
        beat(3'd0, 32'hE0, 1'b0, 1'b0);
        beat(3'd1, 32'hE1, 1'b0, 1'b0);
        bus.err_clr = 1'b1;
        beat(3'd2, 32'hE2, 1'b1, 1'b0);
        bus.err_clr = 1'b0;
        chk("s5_err_len_set_wins", bus.err_len, 1'b1);
        chk("s5_valid",  bus.out_valid, 1'b1);
        chk("s5_fmap",   bus.out_fmap, 72'hE2_000000E1_000000E0);
        chk("s5_weight", $unsigned(bus.out_weight), 72'h00C4_000000C3_000000);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("s5_err_clr", bus.err_len, 1'b0);
        consume();

        // reset in the middle of a load
        beat(3'd0, 32'hF0, 1'b0, 1'b0);
        beat(3'd1, 32'hF1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s6_valid",    bus.out_valid, 1'b0);
        chk("s6_ready",    bus.wr_ready, 1'b1);
        chk("s6_outs",     {bus.out_fmap, $unsigned(bus.out_weight), $unsigned(bus.out_bias)}, 160'd0);

        // fmap-only as first load after reset copies zeroed weights/bias
        for (int k = 0; k < 3; k++) beat(3'(k), 32'h01010101, k == 2, 1'b1);
        chk("s6m1_fmap",   bus.out_fmap, 72'h010101010101010101);
        chk("s6m1_weight", $unsigned(bus.out_weight), 72'd0);
        chk("s6m1_bias",   $unsigned(bus.out_bias), 16'd0);
        consume();

        load_s1();
        check_s1("s6");
        consume();
        chk("s6_done_valid", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
